// File: rtl/serial2tcp_pkg.sv
// Shared mode encoding for the serial2tcp loopback block.
package serial2tcp_pkg;

  typedef enum logic [1:0] {
    MODE_LOOPBACK = 2'd0,
    MODE_GENERATE = 2'd1,
    MODE_CHECK    = 2'd2,
    MODE_RESERVED = 2'd3
  } mode_t;

  // The reserved encoding behaves exactly like LOOPBACK.
  function automatic mode_t decode_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_LOOPBACK : mode_t'(m);
  endfunction

endpackage

// File: rtl/serial2tcp_sync_fifo.sv
// Synchronous FIFO with a registered head word and registered occupancy.
// The head register is loaded with the next word to present, so a word
// pushed into an empty FIFO appears on out_data one edge later.
module serial2tcp_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LW-1:0]         level
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         rd_ptr_nxt;
  logic [LW-1:0]         level_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic                  do_push;
  logic                  do_pop;

  // Full comes from the registered level only, so a pop in the same cycle
  // never makes room for a push.
  assign full       = (level == LW'(DEPTH));
  assign do_push    = push_valid & ~full;
  assign do_pop     = out_valid & out_ready;
  assign rd_ptr_nxt = rd_ptr + AW'(do_pop);
  assign level_nxt  = level + LW'(do_push) - LW'(do_pop);

  // Select the word that will sit on the output after this edge.
  always_comb begin
    head_nxt = out_data;
    if (level_nxt != '0) begin
      if (level == LW'(do_pop)) begin
        head_nxt = push_data;
      end else begin
        head_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  // Storage array, written on every accepted push.
  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr    <= rd_ptr_nxt;
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
      out_data  <= head_nxt;
    end
  end

endmodule

// File: rtl/serial2tcp_stream_loopback.sv
// Stream loopback for serial2tcp link bring-up: buffers sink beats through a
// FIFO back onto the source, or generates / checks a counter pattern.
//
// Handshake: on both streams a beat transfers on a posedge where valid and
// ready are both high; a valid beat holds its data until it transfers, and
// ready never depends combinationally on the other stream's ready.
module serial2tcp_stream_loopback
  import serial2tcp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int ERR_WIDTH  = 16,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [1:0]            mode,
  input  logic                  sink_valid,
  output logic                  sink_ready,
  input  logic [DATA_WIDTH-1:0] sink_data,
  output logic                  source_valid,
  input  logic                  source_ready,
  output logic [DATA_WIDTH-1:0] source_data,
  output logic [1:0]            active_mode,
  output logic [LW-1:0]         level,
  output logic [CNT_WIDTH-1:0]  rx_count,
  output logic [CNT_WIDTH-1:0]  tx_count,
  output logic [ERR_WIDTH-1:0]  err_count
);

  mode_t                 active_q;
  mode_t                 req_mode;
  logic                  switch_pending;
  logic                  run_q;
  logic                  full;
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] gen_q;
  logic [DATA_WIDTH-1:0] expect_q;
  logic                  sink_fire;
  logic                  source_fire;
  logic                  gen_push;

  assign req_mode       = decode_mode(mode);
  assign switch_pending = (req_mode != active_q);
  assign active_mode    = active_q;
  assign sink_fire      = sink_valid & sink_ready;
  assign source_fire    = source_valid & source_ready;
  assign gen_push       = (active_q == MODE_GENERATE) & push_valid & ~full;

  // Route the FIFO push side and sink_ready according to the active mode.
  // run_q keeps sink_ready low for the first cycle out of reset.
  always_comb begin
    push_valid = 1'b0;
    push_data  = sink_data;
    sink_ready = 1'b0;
    if (run_q) begin
      case (active_q)
        MODE_GENERATE: begin
          push_valid = ~switch_pending;
          push_data  = gen_q;
          sink_ready = 1'b1;
        end
        MODE_CHECK: begin
          sink_ready = 1'b1;
        end
        default: begin
          push_valid = sink_valid & ~switch_pending;
          sink_ready = ~full & ~switch_pending;
        end
      endcase
    end
  end

  serial2tcp_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .push_valid (push_valid),
    .push_data  (push_data),
    .full       (full),
    .out_valid  (source_valid),
    .out_ready  (source_ready),
    .out_data   (source_data),
    .level      (level)
  );

  // Mode FSM plus pattern generator and checker; a mode change waits for an
  // empty FIFO so data from the old mode is never mixed with the new one.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      active_q  <= MODE_LOOPBACK;
      run_q     <= 1'b0;
      gen_q     <= '0;
      expect_q  <= '0;
      err_count <= '0;
    end else begin
      run_q <= 1'b1;
      if (switch_pending && level == '0) begin
        active_q <= req_mode;
        if (req_mode == MODE_GENERATE) gen_q <= '0;
        if (req_mode == MODE_CHECK) expect_q <= '0;
      end
      if (gen_push) begin
        gen_q <= gen_q + DATA_WIDTH'(1);
      end
      if (active_q == MODE_CHECK && sink_fire) begin
        if (sink_data == expect_q) begin
          expect_q <= expect_q + DATA_WIDTH'(1);
        end else begin
          // Resync on the received value so a single dropped beat costs one error.
          expect_q <= sink_data + DATA_WIDTH'(1);
          if (err_count != '1) err_count <= err_count + ERR_WIDTH'(1);
        end
      end
    end
  end

  // Wrapping beat counters for both streams.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rx_count <= '0;
      tx_count <= '0;
    end else begin
      rx_count <= rx_count + CNT_WIDTH'(sink_fire);
      tx_count <= tx_count + CNT_WIDTH'(source_fire);
    end
  end

endmodule

// File: tb/tb_serial2tcp_stream_loopback.sv
// Bench for serial2tcp_stream_loopback: directed mode sequence with random
// data, random backpressure and a stream-level reference model.
module tb_serial2tcp_stream_loopback;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 32;
  localparam int EW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  // clock / reset and DUT signals
  logic          sys_clk     = 1'b0;
  logic          sys_rst_n   = 1'b0;
  logic [1:0]    mode        = 2'd0;
  logic          sink_valid  = 1'b0;
  logic [DW-1:0] sink_data   = '0;
  logic          sink_ready;
  logic          source_valid;
  logic          source_ready;
  logic [DW-1:0] source_data;
  logic [1:0]    active_mode;
  logic [LW-1:0] level;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;
  logic [EW-1:0] err_count;

  serial2tcp_stream_loopback #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW),
    .ERR_WIDTH  (EW)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .mode         (mode),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_data    (sink_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_data  (source_data),
    .active_mode  (active_mode),
    .level        (level),
    .rx_count     (rx_count),
    .tx_count     (tx_count),
    .err_count    (err_count)
  );

  always #5 sys_clk = ~sys_clk;

  // scoreboard / reference model state
  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];
  int            rx_exp      = 0;
  int            tx_exp      = 0;
  int            err_exp     = 0;
  logic [DW-1:0] gen_next    = '0;
  logic [DW-1:0] chk_exp     = '0;
  logic [DW-1:0] last_src    = '0;
  logic [1:0]    tb_mode     = 2'd0;
  int            ready_mode  = 0;   // 0 hold low, 1 hold high, 2 random

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // downstream ready driver
  initial begin
    source_ready = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      case (ready_mode)
        0:       source_ready = 1'b0;
        1:       source_ready = 1'b1;
        default: source_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: model of stream behaviour, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (sys_rst_n && sink_valid && sink_ready) begin
      rx_exp++;
      if (tb_mode == 2'd0) begin
        exp_q.push_back(sink_data);
      end else if (tb_mode == 2'd2) begin
        if (sink_data == chk_exp) begin
          chk_exp = chk_exp + 8'd1;
        end else begin
          if (err_exp < 65535) err_exp++;
          chk_exp = sink_data + 8'd1;
        end
      end
    end
    if (sys_rst_n && source_valid && source_ready) begin
      tx_exp++;
      if (exp_q.size() > 0) begin
        check("src_loop_data", source_data, exp_q.pop_front());
      end else begin
        check("src_gen_data", source_data, gen_next);
        gen_next = gen_next + 8'd1;
      end
      last_src = source_data;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int t = 0;
    sink_valid = 1'b1;
    sink_data  = d;
    @(negedge sys_clk);
    while (!sink_ready && t < 2000) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 2000) check("sink_accept_timeout", 32'(sink_ready), 32'd1);
    @(posedge sys_clk);
    #1;
    sink_valid = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    logic [1:0] eff;
    int t = 0;
    eff  = (m == 2'd3) ? 2'd0 : m;
    mode = m;
    @(negedge sys_clk);
    while (active_mode !== eff && t < 2000) begin
      @(negedge sys_clk);
      t++;
    end
    check("mode_switch", 32'(active_mode), 32'(eff));
    tb_mode = eff;
    if (eff == 2'd1) gen_next = '0;
    if (eff == 2'd2) chk_exp = '0;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_drain();
    int t = 0;
    @(negedge sys_clk);
    while (level !== '0 && t < 2000) begin
      @(negedge sys_clk);
      t++;
    end
    check("drain_level", 32'(level), 32'd0);
    check("drain_expq", 32'(exp_q.size()), 32'd0);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_tx(input int n);
    int start = tx_exp;
    int t = 0;
    while (tx_exp - start < n && t < 5000) begin
      @(posedge sys_clk);
      #1;
      t++;
    end
    check("tx_wait", 32'(tx_exp - start), 32'(n));
  endtask

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // directed sequence
  initial begin
    // reset state
    tick(3);
    @(negedge sys_clk);
    check("rst_source_valid", 32'(source_valid), 32'd0);
    check("rst_sink_ready", 32'(sink_ready), 32'd0);
    check("rst_source_data", 32'(source_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_rx", rx_count, 32'd0);
    check("rst_tx", tx_count, 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_active", 32'(active_mode), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    // LOOPBACK 0x00..0x0F, first word one cycle after accept
    ready_mode = 1;
    tick(2);
    send_beat(8'h00);
    @(negedge sys_clk);
    check("first_latency_valid", 32'(source_valid), 32'd1);
    check("first_latency_data", 32'(source_data), 32'd0);
    @(posedge sys_clk);
    #1;
    for (int i = 1; i < 16; i++) send_beat(DW'(i));
    wait_drain();
    check("lb_rx16", rx_count, 32'd16);
    check("lb_tx16", tx_count, 32'd16);
    check("lb_err0", 32'(err_count), 32'd0);

    // LOOPBACK random data, random backpressure and gaps
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send_beat(DW'($urandom));
      tick($urandom_range(0, 2));
    end
    ready_mode = 1;
    wait_drain();
    check("lb_rand_rx", rx_count, 32'(rx_exp));
    check("lb_rand_tx", tx_count, 32'(tx_exp));

    // full FIFO blocks the sink
    ready_mode = 0;
    tick(2);
    for (int i = 0; i < 16; i++) send_beat(DW'($urandom));
    sink_valid = 1'b1;
    sink_data  = DW'($urandom);
    @(negedge sys_clk);
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_sink_ready", 32'(sink_ready), 32'd0);
    check("full_source_valid", 32'(source_valid), 32'd1);
    tick(3);
    @(negedge sys_clk);
    check("full_sink_ready_hold", 32'(sink_ready), 32'd0);
    @(posedge sys_clk);
    #1;
    ready_mode = 1;
    send_beat(sink_data);
    for (int i = 0; i < 3; i++) send_beat(DW'($urandom));
    wait_drain();

    // GENERATE: 300 beats wrap through 0xFF
    set_mode(2'd1);
    wait_tx(300);
    check("gen_300th", 32'(last_src), 32'h2B);
    for (int i = 0; i < 5; i++) send_beat(DW'($urandom));
    tick(1);
    check("gen_rx_discard", rx_count, 32'(rx_exp));

    // back to LOOPBACK, then switch to GENERATE with a backlog of 5
    set_mode(2'd0);
    ready_mode = 0;
    tick(2);
    for (int i = 0; i < 5; i++) send_beat(DW'($urandom));
    mode = 2'd1;
    tick(3);
    @(negedge sys_clk);
    check("pend_active", 32'(active_mode), 32'd0);
    check("pend_sink_ready", 32'(sink_ready), 32'd0);
    check("pend_level", 32'(level), 32'd5);
    @(posedge sys_clk);
    #1;
    ready_mode = 1;
    set_mode(2'd1);
    wait_tx(1);
    check("gen_first", 32'(last_src), 32'h00);
    wait_tx(1);
    check("gen_second", 32'(last_src), 32'h01);

    // CHECK: one dropped beat gives one error
    set_mode(2'd2);
    tick(2);
    @(negedge sys_clk);
    check("chk_source_idle", 32'(source_valid), 32'd0);
    check("chk_level", 32'(level), 32'd0);
    @(posedge sys_clk);
    #1;
    send_beat(8'd0); send_beat(8'd1); send_beat(8'd2);
    send_beat(8'd4); send_beat(8'd5); send_beat(8'd6);
    tick(1);
    check("chk_err1", 32'(err_count), 32'd1);
    send_beat(8'd7);
    tick(1);
    check("chk_expect7", 32'(err_count), 32'd1);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) send_beat(chk_exp + DW'($urandom_range(1, 3)));
      else send_beat(chk_exp);
    end
    tick(1);
    check("chk_rand_err", 32'(err_count), 32'(err_exp));

    // CHECK: error counter saturates
    for (int i = 0; i < 66000; i++) send_beat(8'hAA);
    tick(1);
    check("chk_err_sat", 32'(err_count), 32'hFFFF);
    check("chk_err_model", 32'(err_count), 32'(err_exp));
    check("chk_rx", rx_count, 32'(rx_exp));

    // reset with 8 words buffered
    set_mode(2'd0);
    ready_mode = 0;
    tick(2);
    for (int i = 0; i < 8; i++) send_beat(DW'($urandom));
    @(negedge sys_clk);
    check("pre_rst_level", 32'(level), 32'd8);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    exp_q.delete();
    rx_exp   = 0;
    tx_exp   = 0;
    err_exp  = 0;
    tb_mode  = 2'd0;
    gen_next = '0;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("mid_rst_valid", 32'(source_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_rx", rx_count, 32'd0);
    check("mid_rst_tx", tx_count, 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    check("mid_rst_active", 32'(active_mode), 32'd0);
    @(posedge sys_clk);
    #1;
    ready_mode = 1;
    tick(5);
    check("mid_rst_no_beat", tx_count, 32'd0);

    // recovery traffic
    ready_mode = 2;
    for (int i = 0; i < 10; i++) send_beat(DW'($urandom));
    ready_mode = 1;
    wait_drain();
    check("final_rx", rx_count, 32'(rx_exp));
    check("final_tx", tx_count, 32'(tx_exp));
    check("final_err", 32'(err_count), 32'(err_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial2tcp_stream_loopback.md
Name: serial2tcp_stream_loopback

Overview:
Parametrised successor to the fixed 8-bit serial2tcp loopback. Buffers the sink stream through a synchronous FIFO and returns it on the source stream, with valid/ready backpressure on both sides. Adds run-time modes: counter-pattern generator and pattern checker with error counting. Sits between the serial2tcp bridge and the sim bench, which uses it for link bring-up and throughput checks.

Parameters:
DATA_WIDTH, 8, stream data width in bits (>=1)
DEPTH, 16, FIFO depth in words; power of two, >=2
CNT_WIDTH, 32, width of the rx/tx beat counters (wrap)
ERR_WIDTH, 16, width of the saturating error counter

Ports:
sys_clk  in  1  single clock, all logic on posedge
sys_rst_n  in  1  synchronous reset, active-low
mode  in  2  requested mode: 0 LOOPBACK, 1 GENERATE, 2 CHECK, 3 reserved (acts as LOOPBACK)
sink_valid  in  1  inbound beat valid
sink_ready  out  1  inbound beat accepted when valid&ready
sink_data  in  DATA_WIDTH  inbound data
source_valid  out  1  outbound beat valid
source_ready  in  1  downstream ready
source_data  out  DATA_WIDTH  outbound data
active_mode  out  2  mode currently in effect
level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
rx_count  out  CNT_WIDTH  accepted sink beats, wraps
tx_count  out  CNT_WIDTH  completed source beats, wraps
err_count  out  ERR_WIDTH  CHECK mismatches, saturates at all-ones

Behaviour:
- Reset (sys_rst_n=0 at posedge): FIFO emptied; sink_ready=0, source_valid=0, source_data=0, level=0, rx/tx/err_count=0, active_mode=LOOPBACK, gen and expect counters=0.
- Mode switch: when mode!=active_mode and level==0, active_mode<=mode at next posedge (reserved 3 loads as 0). While mode!=active_mode and level!=0: FIFO push blocked (sink_ready=0 in LOOPBACK/GENERATE push path), source keeps draining. Entering GENERATE clears gen counter; entering CHECK clears expect counter; err_count cleared only by reset.
- FIFO: push when push_valid & !full; pop when source_valid & source_ready. Full blocks push even if pop in same cycle. Simultaneous push and pop when 0<level<DEPTH: level unchanged. Read latency: word pushed into empty FIFO at edge N is on source_data with source_valid=1 after edge N (visible in cycle N+1). source_data/source_valid stable while stalled.
- LOOPBACK: push_valid=sink_valid, push data=sink_data, sink_ready=!full & !switch_pending.
- GENERATE: push data=gen counter (DATA_WIDTH, wraps); push_valid=!switch_pending; gen increments per push. sink_ready=1; sink beats discarded, counted in rx_count.
- CHECK: nothing pushed; source_valid falls once FIFO drained. sink_ready=1. Each accepted beat compared with expect: match -> expect<=expect+1; mismatch -> err_count+1 (saturating), expect<=sink_data+1 (resync, so one dropped beat = one error).
- rx_count increments per sink handshake in any mode; tx_count per source handshake. Both wrap modulo 2^CNT_WIDTH.
- Reset mid-transfer: all buffered data lost, no partial beat emitted after reset.
- No combinational path from source_ready to sink_ready (full computed from registered level).

Decomposition:
- Package serial2tcp_pkg: mode constants MODE_LOOPBACK=0, MODE_GENERATE=1, MODE_CHECK=2; mode typedef (2 bits).
- Sub-module serial2tcp_sync_fifo (DATA_WIDTH, DEPTH): push/pop, full/empty, level, registered output; top holds mode FSM, generator, checker, counters.

Test Plan:
- Reset then LOOPBACK, send 0x00..0x0F with source_ready=1 -> same 16 bytes out in order, first out 1 cycle after first accept; rx_count=tx_count=16, err_count=0.
- LOOPBACK, source_ready=0, push 20 beats -> 16 accepted, sink_ready=0 at level=16; raise source_ready -> remaining 4 accepted, all 20 out in order.
- GENERATE, DATA_WIDTH=8, source_ready=1 for 300 beats -> source_data 0x00..0xFF then wraps to 0x00..0x2B.
- CHECK, send 0,1,2,4,5,6 -> err_count=1, expect=7 at end; send 0xAA x70000 beats at ERR_WIDTH=16 -> err_count saturates 0xFFFF.
- Mode change LOOPBACK->GENERATE with level=5 and source_ready=0 -> active_mode stays 0, sink_ready=0; after 5 pops active_mode=1, next outputs 0x00,0x01.
- Assert sys_rst_n=0 for one cycle with level=8 -> next cycle source_valid=0, level=0, counters 0, active_mode=0.
